// File: rtl/accum_buffer.sv
// accum_buffer
// Fixed-point frame accumulator. It sums ACC_LEN signed samples into a
// guarded accumulator and emits one result per frame. The result is
// saturated when SAT=1 and wrapped when SAT=0. The result sits in a
// one-entry valid/ready output register.
//
// Input backpressure is applied only to the final sample of a frame, and
// only while the previous result is still unpopped. Every earlier sample
// of the next frame flows freely.
//
// Ports
//   clk, rst           rising-edge clock; synchronous active-high reset
//   clr                drop the partial frame (the output register is kept)
//   in_valid/in_ready  sample handshake; in_data is a signed DATA_W sample
//   out_valid/out_ready result handshake; out_data is the converted sum
//   out_ovf            the sum fell outside the DATA_W range
//   count              samples accepted so far in the current frame
module accum_buffer #(
    parameter int DATA_W  = 16,
    parameter int ACC_LEN = 137,
    parameter int GUARD_W = 8,
    parameter bit SAT     = 1'b1,
    parameter int CNT_W   = $clog2(ACC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  count
);
    localparam int ACC_W = DATA_W + GUARD_W;

    // With ACC_LEN <= 2^GUARD_W, a full frame of extreme samples still fits
    // in ACC_W bits. The accumulator therefore never wraps internally.
    if (ACC_LEN < 1 || ACC_LEN > (1 << GUARD_W)) begin : g_bad_len
        $error("accum_buffer: ACC_LEN must lie in 1..2**GUARD_W");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ovf;
    } result_t;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [GUARD_W:0]        top;
    logic                    last;
    logic                    accept;
    logic                    complete;
    logic                    in_range;
    logic [DATA_W-1:0]       clamp;
    result_t                 res_next;
    result_t                 res_q;

    assign last     = (count == CNT_W'(ACC_LEN - 1));
    // Hold off only the frame-closing sample. Otherwise it would overwrite
    // a result that has not been popped yet.
    assign in_ready = ~(last & out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    // A sample accepted under clr is discarded, so it cannot close a frame.
    assign complete = accept & last & ~clr;

    assign sum = acc + {{GUARD_W{in_data[DATA_W-1]}}, in_data};

    // The sum fits in DATA_W exactly when every bit above the DATA_W sign
    // bit matches that sign bit.
    assign top      = sum[ACC_W-1:DATA_W-1];
    assign in_range = (&top) | (~|top);
    assign clamp    = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};

    always_comb begin
        res_next.ovf  = ~in_range;
        res_next.data = sum[DATA_W-1:0];
        if (!in_range && SAT)
            res_next.data = clamp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // A completion in the same cycle as a pop reloads the register.
            if (complete) begin
                out_valid <= 1'b1;
                res_q     <= res_next;
            end
            if (clr) begin
                acc   <= '0;
                count <= '0;
            end else if (accept) begin
                if (last) begin
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= sum;
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign out_data = res_q.data;
    assign out_ovf  = res_q.ovf;
endmodule

// File: tb/tb_accum_buffer.sv
// Directed bench for accum_buffer. It runs three instances:
//   a: ACC_LEN=4, SAT=1
//   w: ACC_LEN=4, SAT=0 (shares all inputs with a)
//   d: default parameters (ACC_LEN=137)
module tb_accum_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clr, in_valid, out_ready;
    logic [15:0] in_data;
    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_data;
    logic [2:0]  a_count;
    logic        w_in_ready, w_out_valid, w_out_ovf;
    logic [15:0] w_out_data;
    logic [2:0]  w_count;

    logic        d_clr, d_in_valid, d_out_ready;
    logic [15:0] d_in_data;
    logic        d_in_ready, d_out_valid, d_out_ovf;
    logic [15:0] d_out_data;
    logic [7:0]  d_count;

    accum_buffer #(.ACC_LEN(4), .SAT(1'b1)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf), .count(a_count));

    accum_buffer #(.ACC_LEN(4), .SAT(1'b0)) u_w (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_ovf(w_out_ovf), .count(w_count));

    accum_buffer u_d (
        .clk(clk), .rst(rst), .clr(d_clr), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_ovf(d_out_ovf), .count(d_count));

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are checked 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        d_clr = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_ovf", a_out_ovf, 0);
        chk("rst_count", a_count, 0);

        // Basic frame: 0x0100 x4 sums to 0x0400.
        in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b1;
        tick(); chk("basic_cnt1", a_count, 1); chk("basic_nv1", a_out_valid, 0);
        tick(); chk("basic_cnt2", a_count, 2);
        tick(); chk("basic_cnt3", a_count, 3); chk("basic_nv3", a_out_valid, 0);
        tick(); chk("basic_cnt0", a_count, 0); chk("basic_valid", a_out_valid, 1);
        chk("basic_data", a_out_data, 16'h0400); chk("basic_ovf", a_out_ovf, 0);
        in_valid = 1'b0;
        tick(); chk("basic_pop", a_out_valid, 0);

        // Positive overflow: 4*0x7000 = 0x1C000.
        in_valid = 1'b1; in_data = 16'h7000;
        repeat (4) tick();
        chk("satp_valid", a_out_valid, 1);
        chk("satp_data", a_out_data, 16'h7FFF); chk("satp_ovf", a_out_ovf, 1);
        chk("wrapp_data", w_out_data, 16'hC000); chk("wrapp_ovf", w_out_ovf, 1);
        // Negative overflow: 4*(-0x7000) = -0x1C000, whose low 16 bits are 0x4000.
        in_data = 16'h9000;
        repeat (4) tick();
        chk("satn_valid", a_out_valid, 1);
        chk("satn_data", a_out_data, 16'h8000); chk("satn_ovf", a_out_ovf, 1);
        chk("wrapn_data", w_out_data, 16'h4000); chk("wrapn_ovf", w_out_ovf, 1);
        in_valid = 1'b0;
        tick(); chk("sat_pop", a_out_valid, 0);

        // Backpressure: stream 1s with no consumer.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
        repeat (4) tick();
        chk("bp_first_valid", a_out_valid, 1); chk("bp_first_data", a_out_data, 4);
        repeat (3) tick();
        chk("bp_count3", a_count, 3); chk("bp_in_ready_lo", a_in_ready, 0);
        tick();
        chk("bp_hold_count", a_count, 3); chk("bp_hold_valid", a_out_valid, 1);
        chk("bp_hold_data", a_out_data, 4);
        out_ready = 1'b1; #1;
        chk("bp_in_ready_hi", a_in_ready, 1);
        tick();
        chk("bp_reload_valid", a_out_valid, 1); chk("bp_reload_data", a_out_data, 4);
        chk("bp_reload_count", a_count, 0);
        in_valid = 1'b0;
        tick(); chk("bp_pop", a_out_valid, 0);

        // clr mid-frame drops 5,5 and the 5 offered under clr.
        in_valid = 1'b1; in_data = 16'd5;
        tick(); tick(); chk("clr_pre_count", a_count, 2);
        clr = 1'b1;
        tick(); chk("clr_count", a_count, 0); chk("clr_valid", a_out_valid, 0);
        clr = 1'b0; in_data = 16'd1;
        repeat (3) tick();
        chk("clr_count3", a_count, 3); chk("clr_nv", a_out_valid, 0);
        tick();
        chk("clr_valid_res", a_out_valid, 1); chk("clr_data", a_out_data, 4);
        in_valid = 1'b0;
        tick();

        // Reset with a result pending and count=2.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd1;
        repeat (6) tick();
        chk("rstp_valid", a_out_valid, 1); chk("rstp_count", a_count, 2);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("rstp_out_valid", a_out_valid, 0); chk("rstp_out_data", a_out_data, 0);
        chk("rstp_count0", a_count, 0); chk("rstp_in_ready", a_in_ready, 1);
        chk("rstp_ovf", a_out_ovf, 0);
        rst = 1'b0;
        tick();

        // Default parameters: 137 samples of -1 give -137 = 0xFF77.
        d_in_valid = 1'b1; d_in_data = 16'hFFFF; d_out_ready = 1'b1;
        repeat (136) tick();
        chk("def_count136", d_count, 136); chk("def_in_ready", d_in_ready, 1);
        chk("def_nv", d_out_valid, 0);
        tick();
        chk("def_valid", d_out_valid, 1); chk("def_data", d_out_data, 16'hFF77);
        chk("def_ovf", d_out_ovf, 0); chk("def_count0", d_count, 0);
        tick();
        chk("def_nobubble", d_count, 1); chk("def_pop", d_out_valid, 0);
        d_in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
